// File: rtl/load_hazard_scoreboard_pkg.sv
// hazard_pkg: shared constants, register index type and counter-width helper for the load hazard scoreboard
package hazard_pkg;
  localparam int NUM_REGS_D   = 32;
  localparam int REG_ADDR_W_D = 5;
  typedef logic [REG_ADDR_W_D-1:0] reg_idx_t;
  function automatic int lat_w(input int l);
    return $clog2(l + 1);
  endfunction
endpackage

// File: rtl/load_hazard_scoreboard_entry.sv
// hazard_sb_entry: one per-register countdown; busy while a load result is not yet forwardable
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CW           = lat_w(LOAD_LATENCY)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  output logic o_busy
);
  logic [CW-1:0] r_cnt;
  assign o_busy = |r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(LOAD_LATENCY);
    else if (i_clear) r_cnt <= '0;
    else if (o_busy) r_cnt <= r_cnt - CW'(1);
  end
endmodule

// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard: per-register countdown load-use hazard unit driving fetch/IF-ID stalls and ID/EX bubbles.
// Optional saturating stall statistics counter enabled by HAZARD_STATS_EN.
module load_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_D,
  parameter int REG_ADDR_W   = REG_ADDR_W_D,
  parameter int LOAD_LATENCY = 1,
  parameter int STAT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_rs_used,
  input  logic                  if_id_rt_used,
  input  logic                  issue_valid,
  input  logic                  issue_mem_read,
  input  logic                  issue_reg_write,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  flush,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  control_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_count
`endif
);
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15 || NUM_REGS != 2**REG_ADDR_W || STAT_W < 1) begin : g_bad_cfg
    $error("load_hazard_scoreboard: illegal parameter combination");
  end
  logic [NUM_REGS-1:0] w_busy;
  logic                w_haz;
  logic                w_issue;
  logic                w_rec_ld;
  logic                w_rec_wr;
  assign w_haz = !flush & ((if_id_rs_used & (if_id_rs != '0) & w_busy[if_id_rs]) |
                           (if_id_rt_used & (if_id_rt != '0) & w_busy[if_id_rt]));
  assign w_issue  = issue_valid & issue_reg_write & !w_haz & !flush;
  assign w_rec_ld = w_issue & issue_mem_read & (issue_rd != '0);
  assign w_rec_wr = w_issue & !issue_mem_read;
  assign control_stall = w_haz;
  assign pc_write      = !w_haz;
  assign if_id_write   = !w_haz;
  // r0 is hard-wired zero, so it never gets an entry
  assign w_busy[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    hazard_sb_entry #(.LOAD_LATENCY(LOAD_LATENCY)) u_entry (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_rec_ld & (issue_rd == REG_ADDR_W'(i))),
      .i_clear(w_rec_wr & (issue_rd == REG_ADDR_W'(i))),
      .o_busy (w_busy[i])
    );
  end
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] r_stall_count;
  assign stall_count = r_stall_count;
  always_ff @(posedge clk) begin
    if (reset) r_stall_count <= '0;
    else if (w_haz && !(&r_stall_count)) r_stall_count <= r_stall_count + STAT_W'(1);
  end
`endif
endmodule
